ctrl_74hc595: RTL and testbench
===============================

CTRL_74HC595 -- requirements
Module: ctrl_74hc595

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter CLK_DIV, default 4, SHALL set the clk cycles per half-period of o_shcp and o_stcp (legal range 1..255).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 i_data  input  12  value to display; no valid strobe, sampled at frame start.
REQ-006 o_oe  output  1  74HC595 output enable, active-low.
REQ-007 o_stcp  output  1  storage-register (latch) clock.
REQ-008 o_shcp  output  1  shift-register clock.
REQ-009 o_ds  output  1  serial data to the first 74HC595.

Function
REQ-010 The FSM SHALL have states LOAD, SHIFT, LATCH; LOAD is entered after reset.
REQ-011 LOAD SHALL last exactly 1 cycle: capture the 16-bit frame {4'b0000, i_data} into the shift register, clear the bit counter, go to SHIFT.
REQ-012 Each bit in SHIFT SHALL take 2*CLK_DIV cycles: o_shcp low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-013 o_ds SHALL equal shift-register bit 15 and be stable for the whole bit period, including across the o_shcp rising edge.
REQ-014 Frames SHALL be sent MSB first; the shift register shifts left by one, and the bit counter increments, at the end of each bit period.
REQ-015 After the 16th bit, the FSM SHALL go to LATCH with o_shcp low.
REQ-016 In LATCH, o_stcp SHALL be high for CLK_DIV cycles, then low for CLK_DIV cycles, then the FSM returns to LOAD.
REQ-017 Frame period SHALL be 1 + 34*CLK_DIV cycles (137 for CLK_DIV=4).
REQ-018 o_stcp and o_shcp SHALL never be high in the same cycle.
REQ-019 o_oe SHALL stay 1 from reset until the cycle after the first o_stcp falling edge, then stay 0 until the next reset.
REQ-020 Changes of i_data during SHIFT or LATCH SHALL NOT affect the frame in flight; they appear in the next frame.
REQ-021 All outputs SHALL be driven directly from flip-flops (glitch-free).

Reset
REQ-022 While rst=1, outputs SHALL be o_oe=1, o_stcp=0, o_shcp=0, o_ds=0, with the FSM in LOAD and the counters cleared.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no o_stcp pulse; the first frame after release starts from LOAD.

Configuration
REQ-024 With macro CTRL_74HC595_ON_CHANGE_EN defined, an extra state IDLE SHALL follow LATCH.
REQ-025 In IDLE, the block SHALL hold all outputs low (except o_oe) and go to LOAD only when i_data differs from the last shifted 12-bit value.
REQ-026 With CTRL_74HC595_ON_CHANGE_EN defined, the first frame after reset SHALL always be sent.
REQ-027 Without CTRL_74HC595_ON_CHANGE_EN, frames SHALL repeat back-to-back continuously (LATCH -> LOAD).

Verification
REQ-028 Reset for 3 cycles, i_data=12'h5A1, CLK_DIV=4 -> bits sampled on o_shcp rising edges = 0000_0101_1010_0001, then one o_stcp pulse of 4 cycles.
REQ-029 Same run -> o_oe=1 through the first frame and 0 afterwards; the second frame repeats 16'h05A1; period is 137 cycles.
REQ-030 i_data changed from 12'h5A1 to 12'hFFF mid-frame -> current frame still shifts 16'h05A1; next frame shifts 16'h0FFF.
REQ-031 rst pulsed during bit 7 -> no o_stcp pulse; o_oe returns to 1; a clean full frame follows after release.
REQ-032 CLK_DIV=1 -> o_shcp toggles every cycle, frame period is 35 cycles, and o_stcp/o_shcp are never both high.
REQ-033 With CTRL_74HC595_ON_CHANGE_EN and constant i_data -> exactly one frame after reset; changing i_data to 12'h001 -> exactly one more frame.

Source files
------------

// File: rtl/ctrl_74hc595.sv
// Serialises {4'b0000, i_data} MSB-first into a 74HC595 chain, then pulses the latch clock.
// Optional macro CTRL_74HC595_ON_CHANGE_EN: after each latch, idle until i_data changes.
module ctrl_74hc595 #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_data,
  output logic        o_oe,
  output logic        o_stcp,
  output logic        o_shcp,
  output logic        o_ds
);

`ifdef CTRL_74HC595_ON_CHANGE_EN
  typedef enum logic [1:0] {LOAD, SHIFT, LATCH, IDLE} state_t;
`else
  typedef enum logic [1:0] {LOAD, SHIFT, LATCH} state_t;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state;
  logic [7:0]  r_div;
  logic        r_half;
  logic [3:0]  r_bit;
  logic [15:0] r_sr;
  logic        r_oe;
  logic        r_stcp;
  logic        r_shcp;
`ifdef CTRL_74HC595_ON_CHANGE_EN
  logic [11:0] r_last;
`endif

  logic w_div_end;
  assign w_div_end = (r_div == DIV_LAST);

  // Every output is a flop; the shift register is emptied by the 16 shifts,
  // so o_ds naturally sits low during LATCH/IDLE.
  assign o_oe   = r_oe;
  assign o_stcp = r_stcp;
  assign o_shcp = r_shcp;
  assign o_ds   = r_sr[15];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_div   <= '0;
      r_half  <= 1'b0;
      r_bit   <= '0;
      r_sr    <= '0;
      r_oe    <= 1'b1;
      r_stcp  <= 1'b0;
      r_shcp  <= 1'b0;
`ifdef CTRL_74HC595_ON_CHANGE_EN
      r_last  <= '0;
`endif
    end else begin
      case (r_state)
        LOAD: begin
          r_sr    <= {4'b0000, i_data};
          r_bit   <= '0;
          r_div   <= '0;
          r_half  <= 1'b0;
          r_shcp  <= 1'b0;
          r_stcp  <= 1'b0;
          r_state <= SHIFT;
`ifdef CTRL_74HC595_ON_CHANGE_EN
          r_last  <= i_data;
`endif
        end
        SHIFT: begin
          if (w_div_end) begin
            r_div  <= '0;
            r_half <= ~r_half;
            if (!r_half) begin
              r_shcp <= 1'b1;
            end else begin
              // Data moves only as o_shcp falls, so o_ds is stable across the rising edge.
              r_shcp <= 1'b0;
              r_sr   <= {r_sr[14:0], 1'b0};
              r_bit  <= r_bit + 4'd1;
              if (r_bit == 4'd15) begin
                r_state <= LATCH;
                r_stcp  <= 1'b1;
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        LATCH: begin
          if (w_div_end) begin
            r_div  <= '0;
            r_half <= ~r_half;
            if (!r_half) begin
              r_stcp <= 1'b0;
              r_oe   <= 1'b0;
            end else begin
`ifdef CTRL_74HC595_ON_CHANGE_EN
              r_state <= IDLE;
`else
              r_state <= LOAD;
`endif
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
`ifdef CTRL_74HC595_ON_CHANGE_EN
        IDLE: begin
          if (i_data != r_last) r_state <= LOAD;
        end
`endif
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_74hc595.sv
// Directed bench for ctrl_74hc595: CLK_DIV=4 instance for frame content/timing, CLK_DIV=1 instance for fast mode.
module tb_ctrl_74hc595;
  logic        clk = 1'b0;
  logic        rst, rst1;
  logic [11:0] i_data, i_data1;
  logic        o_oe, o_stcp, o_shcp, o_ds;
  logic        o1_oe, o1_stcp, o1_shcp, o1_ds;

  int checks = 0;
  int passes = 0;

  ctrl_74hc595 #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .i_data(i_data),
    .o_oe(o_oe), .o_stcp(o_stcp), .o_shcp(o_shcp), .o_ds(o_ds)
  );

  ctrl_74hc595 #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .i_data(i_data1),
    .o_oe(o1_oe), .o_stcp(o1_stcp), .o_shcp(o1_shcp), .o_ds(o1_ds)
  );

  always #5 clk = ~clk;

  // Free-running observers for latch-pulse spacing and shcp/stcp overlap
  int   cyc = 0, last_rise = 0, period = 0, stcp_rises = 0;
  int   overlap4 = 0, overlap1 = 0;
  logic prev_stcp = 1'b0;
  always @(negedge clk) begin
    if (o_stcp === 1'b1 && o_shcp === 1'b1) overlap4++;
    if (o1_stcp === 1'b1 && o1_shcp === 1'b1) overlap1++;
    if (o_stcp === 1'b1 && prev_stcp === 1'b0) begin
      stcp_rises++;
      period    = cyc - last_rise;
      last_rise = cyc;
    end
    prev_stcp = o_stcp;
    cyc++;
  end

  logic [15:0] bits;
  int          stlen;
  bit          seen0, seen1, unst, tmo;

  // Collect bits on o_shcp rising edges until the o_stcp falling edge (or give up).
  task automatic capture(input int chg_at, input logic [11:0] chg_val,
                         output logic [15:0] b, output int sl, output bit s0,
                         output bit s1, output bit un, output bit to);
    int   n = 0, guard = 0;
    logic ps, pst, pds;
    b = '0; sl = 0; s0 = 0; s1 = 0; un = 0; to = 0;
    ps = o_shcp; pst = o_stcp; pds = o_ds;
    while (1) begin
      @(negedge clk);
      guard++;
      if (o_stcp === 1'b0 && pst === 1'b1) break;
      if (o_oe === 1'b1) s1 = 1; else s0 = 1;
      if (o_shcp === 1'b1 && ps === 1'b0) begin
        b = {b[14:0], o_ds};
        if (o_ds !== pds) un = 1;
        n++;
        if (n == chg_at) i_data = chg_val;
      end
      if (o_stcp === 1'b1) sl++;
      ps = o_shcp; pst = o_stcp; pds = o_ds;
      if (guard > 400) begin
        to = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1; i_data = 12'h5A1; i_data1 = 12'hA5C;
    repeat (3) @(negedge clk);
    checks++; if (o_oe !== 1'b1)   $display("FAIL rst_oe got %b exp 1", o_oe);     else passes++;
    checks++; if (o_stcp !== 1'b0) $display("FAIL rst_stcp got %b exp 0", o_stcp); else passes++;
    checks++; if (o_shcp !== 1'b0) $display("FAIL rst_shcp got %b exp 0", o_shcp); else passes++;
    checks++; if (o_ds !== 1'b0)   $display("FAIL rst_ds got %b exp 0", o_ds);     else passes++;
    checks++; if (o1_oe !== 1'b1)  $display("FAIL rst1_oe got %b exp 1", o1_oe);   else passes++;
    rst = 1'b0;
  endtask

  task automatic test_frame();
    capture(0, 12'h000, bits, stlen, seen0, seen1, unst, tmo);
    checks++; if (tmo !== 1'b0)      $display("FAIL f1_timeout got %b exp 0", tmo);        else passes++;
    checks++; if (bits !== 16'h05A1) $display("FAIL f1_bits got %h exp 05a1", bits);       else passes++;
    checks++; if (stlen != 4)        $display("FAIL f1_stcp_len got %0d exp 4", stlen);    else passes++;
    checks++; if (seen0 !== 1'b0)    $display("FAIL f1_oe_low_early got %b exp 0", seen0); else passes++;
    checks++; if (unst !== 1'b0)     $display("FAIL f1_ds_unstable got %b exp 0", unst);   else passes++;
  endtask

`ifdef CTRL_74HC595_ON_CHANGE_EN
  task automatic test_on_change();
    capture(0, 12'h000, bits, stlen, seen0, seen1, unst, tmo);
    checks++; if (tmo !== 1'b1) $display("FAIL idle_timeout got %b exp 1", tmo);   else passes++;
    checks++; if (stlen != 0)   $display("FAIL idle_stcp got %0d exp 0", stlen);   else passes++;
    checks++; if (o_oe !== 1'b0) $display("FAIL idle_oe got %b exp 0", o_oe);      else passes++;
    i_data = 12'h001;
    capture(0, 12'h000, bits, stlen, seen0, seen1, unst, tmo);
    checks++; if (bits !== 16'h0001) $display("FAIL chg_bits got %h exp 0001", bits); else passes++;
    checks++; if (stlen != 4)        $display("FAIL chg_stcp_len got %0d exp 4", stlen); else passes++;
    capture(0, 12'h000, bits, stlen, seen0, seen1, unst, tmo);
    checks++; if (tmo !== 1'b1) $display("FAIL chg_once got timeout %b exp 1", tmo); else passes++;
  endtask
`else
  task automatic test_back_to_back();
    capture(0, 12'h000, bits, stlen, seen0, seen1, unst, tmo);
    checks++; if (bits !== 16'h05A1) $display("FAIL f2_bits got %h exp 05a1", bits);        else passes++;
    checks++; if (seen1 !== 1'b0)    $display("FAIL f2_oe_high got %b exp 0", seen1);       else passes++;
    checks++; if (period != 137)     $display("FAIL f2_period got %0d exp 137", period);    else passes++;
  endtask
`endif

  task automatic test_data_change();
    do_reset();
    capture(5, 12'hFFF, bits, stlen, seen0, seen1, unst, tmo);
    checks++; if (bits !== 16'h05A1) $display("FAIL dc_cur_bits got %h exp 05a1", bits); else passes++;
    capture(0, 12'h000, bits, stlen, seen0, seen1, unst, tmo);
    checks++; if (bits !== 16'h0FFF) $display("FAIL dc_next_bits got %h exp 0fff", bits); else passes++;
    checks++; if (tmo !== 1'b0)      $display("FAIL dc_timeout got %b exp 0", tmo);        else passes++;
  endtask

  task automatic test_reset_midframe();
    int r0;
    i_data = 12'h5A1;
    do_reset();
    capture(0, 12'h000, bits, stlen, seen0, seen1, unst, tmo);
    i_data = 12'h123;
    repeat (64) @(negedge clk);
    checks++; if (o_oe !== 1'b0) $display("FAIL mid_pre_oe got %b exp 0", o_oe); else passes++;
    r0 = stcp_rises;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (o_oe !== 1'b1)   $display("FAIL mid_oe got %b exp 1", o_oe);     else passes++;
    checks++; if (o_shcp !== 1'b0) $display("FAIL mid_shcp got %b exp 0", o_shcp); else passes++;
    checks++; if (o_ds !== 1'b0)   $display("FAIL mid_ds got %b exp 0", o_ds);     else passes++;
    rst = 1'b0;
    capture(0, 12'h000, bits, stlen, seen0, seen1, unst, tmo);
    checks++; if (stcp_rises != r0 + 1) $display("FAIL mid_no_latch got %0d rises exp %0d", stcp_rises - r0, 1); else passes++;
    checks++; if (bits !== 16'h0123) $display("FAIL mid_after_bits got %h exp 0123", bits); else passes++;
    checks++; if (stlen != 4)        $display("FAIL mid_after_stcp got %0d exp 4", stlen);  else passes++;
    checks++; if (seen0 !== 1'b0)    $display("FAIL mid_after_oe got %b exp 0", seen0);    else passes++;
  endtask

  task automatic test_clkdiv1();
    int          bad = 0, n;
    logic [15:0] b1 = '0;
    i_data1 = 12'hA5C;
    rst1 = 1'b1;
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k <= 32) begin
        if (o1_shcp !== (k % 2 == 0)) bad++;
        if (k % 2 == 0) b1 = {b1[14:0], o1_ds};
      end
    end
    checks++; if (bad != 0)         $display("FAIL d1_toggle got %0d bad cycles exp 0", bad); else passes++;
    checks++; if (b1 !== 16'h0A5C)  $display("FAIL d1_bits got %h exp 0a5c", b1);             else passes++;
    checks++; if (o1_stcp !== 1'b1) $display("FAIL d1_stcp got %b exp 1", o1_stcp);           else passes++;
    @(negedge clk);
    i_data1 = 12'h3C6;
    n = 34;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (o1_stcp === 1'b1) break;
    end
`ifdef CTRL_74HC595_ON_CHANGE_EN
    checks++; if (n != 69) $display("FAIL d1_next_latch got cycle %0d exp 69", n); else passes++;
`else
    checks++; if (n != 68) $display("FAIL d1_period got cycle %0d exp 68", n); else passes++;
`endif
  endtask

  task automatic test_overlap();
    checks++; if (overlap4 != 0) $display("FAIL overlap_div4 got %0d exp 0", overlap4); else passes++;
    checks++; if (overlap1 != 0) $display("FAIL overlap_div1 got %0d exp 0", overlap1); else passes++;
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1; i_data = 12'h5A1; i_data1 = 12'hA5C;
    @(negedge clk);
    test_reset();
    test_frame();
`ifdef CTRL_74HC595_ON_CHANGE_EN
    test_on_change();
`else
    test_back_to_back();
`endif
    i_data = 12'h5A1;
    test_data_change();
    test_reset_midframe();
    test_clkdiv1();
    test_overlap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
